// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and op decode helpers for muldiv_unit
package muldiv_pkg;

    // funct3 encodings of the RV32M ops
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with start/busy/done handshake
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start, op      request and funct3 op; sampled only in IDLE or DONE
//   A, B           operands rs1, rs2
//   busy           high during CALC and FIX
//   done           one-cycle pulse, Result valid
//   Result         registered result, held until the next completion
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Result
);

    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
    localparam logic [N-1:0]  INT_MIN  = {1'b1, {(N-1){1'b0}}};

    state_t         state, state_nxt;
    logic [2*N-1:0] acc, acc_nxt;
    logic [N-1:0]   b_mag_q;
    logic [2:0]     op_q;
    logic           neg_q, neg_r;
    logic [CW-1:0]  cnt;

    logic           accept, sa, sb, div_zero, div_ovf, special, op_div;
    logic [N-1:0]   a_mag, b_mag, special_res;
    logic [N:0]     add_l, add_r, add_sum;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quo, rem, fix_res;

    // Accept-time decode: magnitudes, sign flags and the single-cycle special cases
    always_comb begin
        accept   = start && (state == ST_IDLE || state == ST_DONE);
        sa       = is_signed_a(op) && A[N-1];
        sb       = is_signed_b(op) && B[N-1];
        a_mag    = sa ? -A : A;
        b_mag    = sb ? -B : B;
        div_zero = is_div(op) && (B == '0);
        // op[0]==0 selects the signed divide ops (DIV, REM)
        div_ovf  = is_div(op) && !op[0] && (A == INT_MIN) && (B == '1);
        special  = div_zero || div_ovf;
        if (div_zero) special_res = op[1] ? A : '1;
        else          special_res = op[1] ? '0 : A;
    end

    // Shared (N+1)-bit adder: add multiplicand for multiply, subtract divisor for divide.
    // acc holds {high/remainder, low/multiplier-or-quotient}.
    always_comb begin
        op_div  = is_div(op_q);
        add_l   = op_div ? acc[2*N-1:N-1] : {1'b0, acc[2*N-1:N]};
        add_r   = op_div ? ~{1'b0, b_mag_q} : {1'b0, b_mag_q};
        add_sum = add_l + add_r + {{N{1'b0}}, op_div};
        if (op_div) begin
            // negative trial difference restores (keeps the shifted remainder)
            if (add_sum[N]) acc_nxt = {acc[2*N-2:0], 1'b0};
            else            acc_nxt = {add_sum[N-1:0], acc[N-2:0], 1'b1};
        end else begin
            if (acc[0]) acc_nxt = {add_sum, acc[N-1:1]};
            else        acc_nxt = {1'b0, acc[2*N-1:1]};
        end
    end

    // Sign correction and result select
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[N-1:0] : acc[N-1:0];
        rem  = neg_r ? -acc[2*N-1:N] : acc[2*N-1:N];
        if (op_div)                 fix_res = op_q[1] ? rem : quo;
        else if (op_q[1:0] == 2'b00) fix_res = prod[N-1:0];
        else                        fix_res = prod[2*N-1:N];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done = (state == ST_DONE);
                if (accept) state_nxt = special ? ST_DONE : ST_CALC;
                else        state_nxt = ST_IDLE;
            end
            ST_CALC: begin
                busy = 1'b1;
                if (cnt == '0) state_nxt = ST_FIX;
            end
            ST_FIX: begin
                busy      = 1'b1;
                state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            b_mag_q <= '0;
            op_q    <= OP_MUL;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            cnt     <= '0;
            Result  <= '0;
        end else if (accept) begin
            op_q    <= op;
            b_mag_q <= b_mag;
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            acc     <= {{N{1'b0}}, a_mag};
            cnt     <= CNT_INIT;
            if (special) Result <= special_res;
        end else if (state == ST_CALC) begin
            acc <= acc_nxt;
            if (cnt != '0) cnt <= cnt - 1'b1;
        end else if (state == ST_FIX) begin
            Result <= fix_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    op;
    logic [N-1:0]  a, b;
    logic          busy, done;
    logic [N-1:0]  result;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .A      (a),
        .B      (b),
        .busy   (busy),
        .done   (done),
        .Result (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint     sx, sy, uy, q;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        uy = longint'({32'b0, y});
        case (f)
            3'd0: begin p = 64'(sx * sy); return p[31:0]; end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                q = sx / sy;
                return q[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                q = sx % sy;
                return q[31:0];
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (!f[2]) return 1'b0;
        if (y == 0) return 1'b1;
        return (f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
    endfunction

    // Starts at a negedge, returns at the negedge of the done cycle. poke >= 0 pulses a
    // stray start with junk operands that many cycles into the operation.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input int poke, input string tag);
        int          lat, busy_cnt, exp_lat;
        logic [31:0] prev, exp_v;
        logic        stable;
        bit          sp;
        exp_v   = ref_model(f, x, y);
        sp      = is_special(f, x, y);
        exp_lat = sp ? 0 : N + 1;
        prev    = result;
        stable  = 1'b1;
        op = f; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom);
        @(negedge clk);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (result !== prev) stable = 1'b0;
            if (poke >= 0 && lat == poke) begin
                start = 1'b1; a = $urandom; b = $urandom; op = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check_eq($sformatf("%s result", tag), result, exp_v);
        check_eq($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        check_eq($sformatf("%s busy cycles", tag), 32'(busy_cnt), 32'(exp_lat));
        check_eq($sformatf("%s busy at done", tag), {31'b0, busy}, 32'd0);
        if (!sp) check_eq($sformatf("%s result stable", tag), {31'b0, stable}, 32'd1);
    endtask

    task automatic gap(input string tag);
        @(negedge clk);
        check_eq($sformatf("%s done pulse", tag), {31'b0, done}, 32'd0);
    endtask

    logic [2:0]  d_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                               32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp[12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                               32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

    initial begin
        int          done_seen;
        logic [2:0]  f;
        logic [31:0] x, y;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check_eq("reset busy", {31'b0, busy}, 32'd0);
        check_eq("reset done", {31'b0, done}, 32'd0);
        check_eq("reset result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            check_eq($sformatf("model dir%0d", i), ref_model(d_op[i], d_a[i], d_b[i]), d_exp[i]);
            run_op(d_op[i], d_a[i], d_b[i], -1, $sformatf("dir%0d", i));
            gap($sformatf("dir%0d", i));
        end

        run_op(3'd5, 32'd100, 32'd7, 5, "poke div");
        gap("poke div");
        run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 20, "poke mulh");
        gap("poke mulh");

        run_op(3'd3, 32'hDEAD_BEEF, 32'h0BAD_F00D, -1, "b2b0");
        run_op(3'd6, 32'hFFFF_FF00, 32'd7, -1, "b2b1");
        run_op(3'd4, 32'd9, 32'd0, -1, "b2b2");
        run_op(3'd0, 32'h0001_0003, 32'hFFFF_0005, -1, "b2b3");
        gap("b2b3");

        op = 3'd4; a = 32'h7FFF_0000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("mid calc busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort busy", {31'b0, busy}, 32'd0);
        check_eq("abort done", {31'b0, done}, 32'd0);
        check_eq("abort result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check_eq("no done after abort", 32'(done_seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = $urandom_range(0, 300); y = $urandom_range(1, 20); end
                3: y = {{16{y[15]}}, y[15:0]};
                default: ;
            endcase
            run_op(f, x, y, -1, $sformatf("rnd%0d op%0d", i, f));
            if ($urandom_range(0, 1) == 1) gap($sformatf("rnd%0d", i));
        end
        gap("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
